// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between N_SRC byte sources.
// Optional stall timeout is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int N_SRC       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [N_SRC-1:0]   req,
  input  logic [N_SRC-1:0]   last,
  input  logic [8*N_SRC-1:0] data,
  output logic [N_SRC-1:0]   ack,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_out,
  input  logic               tx_busy,
  output logic               timeout
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  generate
    if (N_SRC < 2 || N_SRC > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("uart_tx_arb: N_SRC must be 2..8 and TIMEOUT_CYC at least 1");
    end
  endgenerate

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] cand;
  logic          pick_found;
  logic          issue;
  logic          timeout_fire;

  // First requester strictly after the last released owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = PW'((int'(ptr) + k) % N_SRC);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // tx_out high means the UART has not yet raised busy for the byte just loaded.
  assign issue = (state == SEND) && req[owner] && !tx_busy && !tx_out;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] stall_cnt;

  assign timeout_fire = (state == SEND) && !issue && req[owner] &&
                        (stall_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= timeout_fire;
      if (state != SEND || issue)
        stall_cnt <= '0;
      else if (stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Grant drops as soon as the packet ends so two dead cycles separate packets.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      ptr     <= PW'(N_SRC - 1);
      ack     <= '0;
      tx_out  <= 1'b0;
      tx_data <= '0;
    end else begin
      ack    <= '0;
      tx_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= ONE << pick_idx;
            owner <= pick_idx;
            state <= SEND;
          end
        end
        SEND: begin
          if (issue) begin
            tx_data <= data[{owner, 3'b000} +: 8];
            tx_out  <= 1'b1;
            ack     <= grant;
            if (last[owner]) begin
              grant <= '0;
              state <= RELEASE;
            end
          end else if (!req[owner] || timeout_fire) begin
            grant <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          grant <= '0;
          ptr   <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed testbench for uart_tx_arb: bench-side UART busy model and byte-queue sources.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        nRst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_out;
  logic        tx_busy = 1'b0;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] mem [4][8];
  int head [4];
  int len [4];
  int ack_cnt [4];
  logic [7:0] log_data [16];
  int log_step [16];
  int n_log;
  int step_no;
  int timeout_cnt;
  logic [3:0] ep_grant [8];
  int ep_start [8];
  int ep_end [8];
  int n_ep;
  logic [3:0] prev_grant;

  int busy_len = 4;
  bit busy_stuck = 1'b0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.N_SRC(4), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .req     (req),
    .last    (last),
    .data    (data),
    .ack     (ack),
    .grant   (grant),
    .tx_data (tx_data),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .timeout (timeout)
  );

  // UART stand-in: busy for busy_len cycles starting the cycle after a load strobe.
  always @(posedge clk) begin
    if (busy_stuck) tx_busy <= 1'b1;
    else if (tx_out) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else tx_busy <= 1'b0;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_sources();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < len[i]) begin
        req[i] = 1'b1;
        last[i] = mem[i][head[i]][8];
        data[8*i +: 8] = mem[i][head[i]][7:0];
      end else begin
        req[i] = 1'b0;
        last[i] = 1'b0;
        data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      len[i] = 0;
    end
    drive_sources();
  endtask

  task automatic clear_obs();
    step_no = 0;
    n_log = 0;
    timeout_cnt = 0;
    n_ep = 0;
    prev_grant = grant;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
  endtask

  // One cycle: observe at the falling edge, then let sources react to acks.
  task automatic step();
    @(negedge clk);
    step_no++;
    if (tx_out) begin
      if (n_log < 16) begin
        log_data[n_log] = tx_data;
        log_step[n_log] = step_no;
      end
      n_log++;
    end
    if (timeout) timeout_cnt++;
    if (grant !== prev_grant) begin
      if (grant !== 4'b0000) begin
        if (n_ep < 8) begin
          ep_grant[n_ep] = grant;
          ep_start[n_ep] = step_no;
          ep_end[n_ep] = -1;
        end
        n_ep++;
      end else if (n_ep > 0 && n_ep <= 8) ep_end[n_ep-1] = step_no;
      prev_grant = grant;
    end
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        ack_cnt[i]++;
        head[i]++;
      end
    end
    drive_sources();
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    req = '0; last = '0; data = '0;
    clear_queues();
    step();
    step();
    vectors++;
    if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    vectors++;
    if (ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    vectors++;
    if (tx_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_out: got %b expected 0", tx_out); end
    vectors++;
    if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    nRst = 1'b1;
    step();
    step();
    vectors++;
    if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL idle_no_req_grant: got %b expected 0000", grant); end
  endtask

  task automatic test_single_packet();
    int first_grant;
    int grant_end;
    int bad_grant;
    clear_queues();
    busy_len = 10;
    mem[0][0] = {1'b0, 8'h41};
    mem[0][1] = {1'b0, 8'h42};
    mem[0][2] = {1'b1, 8'h43};
    len[0] = 3;
    clear_obs();
    drive_sources();
    first_grant = -1; grant_end = -1; bad_grant = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (grant !== 4'b0000 && first_grant < 0) first_grant = step_no;
      if (grant !== 4'b0000 && grant !== 4'b0001) bad_grant++;
      if (first_grant >= 0 && grant === 4'b0000 && grant_end < 0) grant_end = step_no;
    end
    vectors++;
    if (first_grant != 1) begin miscompares++; $display("[TB] FAIL single_grant_latency: got %0d expected 1", first_grant); end
    vectors++;
    if (n_log != 3) begin miscompares++; $display("[TB] FAIL single_byte_count: got %0d expected 3", n_log); end
    else begin
      vectors++;
      if (log_data[0] !== 8'h41 || log_data[1] !== 8'h42 || log_data[2] !== 8'h43) begin
        miscompares++;
        $display("[TB] FAIL single_bytes: got %h %h %h expected 41 42 43", log_data[0], log_data[1], log_data[2]);
      end
      vectors++;
      if (log_step[0] != 2 || log_step[1] != 14 || log_step[2] != 26) begin
        miscompares++;
        $display("[TB] FAIL single_issue_cycles: got %0d %0d %0d expected 2 14 26", log_step[0], log_step[1], log_step[2]);
      end
    end
    vectors++;
    if (ack_cnt[0] != 3 || ack_cnt[1] + ack_cnt[2] + ack_cnt[3] != 0) begin
      miscompares++;
      $display("[TB] FAIL single_acks: got %0d/%0d/%0d/%0d expected 3/0/0/0", ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
    vectors++;
    if (bad_grant != 0) begin miscompares++; $display("[TB] FAIL single_grant_onehot: got %0d bad cycles expected 0", bad_grant); end
    vectors++;
    if (grant_end != 26) begin miscompares++; $display("[TB] FAIL single_grant_release: got %0d expected 26", grant_end); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    nRst = 1'b0;
    clear_queues();
    busy_len = 2;
    mem[0][0] = {1'b1, 8'h10};
    mem[0][1] = {1'b1, 8'h11};
    mem[1][0] = {1'b1, 8'h20};
    mem[2][0] = {1'b1, 8'h30};
    mem[3][0] = {1'b1, 8'h40};
    len[0] = 2; len[1] = 1; len[2] = 1; len[3] = 1;
    drive_sources();
    step();
    clear_obs();
    nRst = 1'b1;
    for (int k = 0; k < 80; k++) step();
    vectors++;
    if (n_ep != 5) begin miscompares++; $display("[TB] FAIL contention_packets: got %0d expected 5", n_ep); end
    else begin
      for (int e = 0; e < 5; e++) begin
        vectors++;
        if (ep_grant[e] !== exp_g[e]) begin
          miscompares++;
          $display("[TB] FAIL contention_order[%0d]: got %b expected %b", e, ep_grant[e], exp_g[e]);
        end
      end
      for (int e = 0; e < 4; e++) begin
        vectors++;
        if (ep_start[e+1] - ep_end[e] != 2) begin
          miscompares++;
          $display("[TB] FAIL contention_dead[%0d]: got %0d expected 2", e, ep_start[e+1] - ep_end[e]);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp_d [5];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3; exp_d[4] = 8'h55;
    clear_queues();
    busy_len = 4;
    mem[2][0] = {1'b0, 8'hA0};
    mem[2][1] = {1'b0, 8'hA1};
    mem[2][2] = {1'b0, 8'hA2};
    mem[2][3] = {1'b1, 8'hA3};
    mem[0][0] = {1'b1, 8'h55};
    len[2] = 4;
    clear_obs();
    drive_sources();
    for (int k = 0; k < 100; k++) begin
      step();
      if (ack_cnt[2] == 2 && len[0] == 0) begin
        len[0] = 1;
        drive_sources();
      end
    end
    vectors++;
    if (n_log != 5) begin miscompares++; $display("[TB] FAIL lock_byte_count: got %0d expected 5", n_log); end
    else begin
      for (int b = 0; b < 5; b++) begin
        vectors++;
        if (log_data[b] !== exp_d[b]) begin
          miscompares++;
          $display("[TB] FAIL lock_byte[%0d]: got %h expected %h", b, log_data[b], exp_d[b]);
        end
      end
    end
    vectors++;
    if (n_ep != 2 || ep_grant[0] !== 4'b0100 || ep_grant[1] !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL lock_grants: got %0d packets %b %b expected 2 packets 0100 0001", n_ep, ep_grant[0], ep_grant[1]);
    end
  endtask

  task automatic test_abandon();
    int ack_step;
    int zero_step;
    clear_queues();
    busy_len = 3;
    mem[1][0] = {1'b0, 8'h77};
    len[1] = 1;
    clear_obs();
    drive_sources();
    ack_step = -1; zero_step = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack_cnt[1] > 0 && ack_step < 0) ack_step = step_no;
      if (ack_step >= 0 && grant === 4'b0000 && zero_step < 0) zero_step = step_no;
    end
    vectors++;
    if (ack_step != 2) begin miscompares++; $display("[TB] FAIL abandon_ack_cycle: got %0d expected 2", ack_step); end
    vectors++;
    if (zero_step - ack_step != 1) begin miscompares++; $display("[TB] FAIL abandon_release: got %0d cycles expected 1", zero_step - ack_step); end
    vectors++;
    if (n_log != 1 || ack_cnt[1] != 1) begin
      miscompares++;
      $display("[TB] FAIL abandon_bytes: got %0d strobes %0d acks expected 1 1", n_log, ack_cnt[1]);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] g_hist [64];
    int to_step;
    clear_queues();
    busy_stuck = 1'b1;
    step(); step(); step();
    mem[3][0] = {1'b1, 8'h33};
    mem[0][0] = {1'b1, 8'h03};
    len[3] = 1; len[0] = 1;
    clear_obs();
    drive_sources();
    to_step = -1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < 24; k++) begin
      step();
      g_hist[step_no] = grant;
      if (timeout === 1'b1 && to_step < 0) to_step = step_no;
    end
    vectors++;
    if (g_hist[1] !== 4'b1000) begin miscompares++; $display("[TB] FAIL timeout_first_grant: got %b expected 1000", g_hist[1]); end
    vectors++;
    if (to_step != 17) begin miscompares++; $display("[TB] FAIL timeout_cycle: got %0d expected 17", to_step); end
    vectors++;
    if (timeout_cnt != 1) begin miscompares++; $display("[TB] FAIL timeout_pulse_width: got %0d expected 1", timeout_cnt); end
    vectors++;
    if (g_hist[17] !== 4'b0000) begin miscompares++; $display("[TB] FAIL timeout_release: got %b expected 0000", g_hist[17]); end
    vectors++;
    if (g_hist[19] !== 4'b0001) begin miscompares++; $display("[TB] FAIL timeout_next_grant: got %b expected 0001", g_hist[19]); end
`else
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
        step();
        g_hist[step_no] = grant;
        if (grant !== 4'b1000) bad++;
      end
      vectors++;
      if (g_hist[1] !== 4'b1000) begin miscompares++; $display("[TB] FAIL hold_first_grant: got %b expected 1000", g_hist[1]); end
      vectors++;
      if (bad != 0) begin miscompares++; $display("[TB] FAIL hold_grant: got %0d cycles without 1000 expected 0", bad); end
      vectors++;
      if (timeout_cnt != 0) begin miscompares++; $display("[TB] FAIL hold_timeout: got %0d pulses expected 0", timeout_cnt); end
    end
`endif
    vectors++;
    if (n_log != 0) begin miscompares++; $display("[TB] FAIL stall_no_strobe: got %0d strobes expected 0", n_log); end
    for (int i = 0; i < 4; i++) len[i] = head[i];
    drive_sources();
    busy_stuck = 1'b0;
    for (int k = 0; k < 20; k++) step();
  endtask

  task automatic test_reset_mid_byte();
    bit found;
    clear_queues();
    busy_len = 2;
    mem[1][0] = {1'b1, 8'h11};
    len[1] = 1;
    clear_obs();
    drive_sources();
    for (int k = 0; k < 12; k++) step();
    vectors++;
    if (n_log != 1 || log_data[0] !== 8'h11) begin
      miscompares++;
      $display("[TB] FAIL midreset_setup: got %0d strobes data %h expected 1 11", n_log, log_data[0]);
    end
    clear_queues();
    mem[2][0] = {1'b1, 8'h22};
    mem[0][0] = {1'b1, 8'h05};
    len[2] = 1;
    drive_sources();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (grant === 4'b0100) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("[TB] FAIL midreset_grant_wait: got no grant expected 0100"); end
    else begin
      nRst = 1'b0;
      #1;
      vectors++;
      if (grant !== 4'b0000 || ack !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL midreset_grant_ack: got %b %b expected 0000 0000", grant, ack);
      end
      vectors++;
      if (tx_out !== 1'b0 || tx_data !== 8'h00 || timeout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midreset_tx: got %b %h %b expected 0 00 0", tx_out, tx_data, timeout);
      end
      len[0] = 1;
      drive_sources();
      step();
      nRst = 1'b1;
      step();
      vectors++;
      if (grant !== 4'b0001) begin miscompares++; $display("[TB] FAIL midreset_priority: got %b expected 0001", grant); end
    end
    for (int k = 0; k < 30; k++) step();
  endtask

  initial begin
    $display("[TB] uart_tx_arb directed test start");
    test_reset();
    test_single_packet();
    test_contention();
    test_packet_lock();
    test_abandon();
    test_timeout();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
